// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
// Latency: grant edge -> tx_start 1 clk; tx_busy fall -> next req_ready GAP_CLKS+1 clks.
// Backpressure: req_ready pulses one-hot only in IDLE when tx_busy=0; otherwise requesters wait.
// Optional build macro UART_ARB_SRCID_EN: prefix each payload with a header frame {4'hA, grant_id}.
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int GAP_CLKS = 87,
  parameter int IDW      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  input  logic                 tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 active
);

  // Counter holds at most GAP_CLKS-1; keep at least one bit so GAP_CLKS of 0 or 1 still elaborates.
  localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [IDW-1:0] win;
  logic [IDW-1:0] cand;
  logic           win_vld;
  logic           frame_done;
  logic           hdr_pend;

`ifdef UART_ARB_SRCID_EN
  logic [7:0]     payload_q, payload_d;
  logic           hdr_pend_q, hdr_pend_d;
  assign hdr_pend = hdr_pend_q;
`else
  assign hdr_pend = 1'b0;
`endif

  // Round-robin search: nearest valid requester after the last grant, wrapping modulo N_REQ.
  always_comb begin
    win     = grant_id_q;
    win_vld = 1'b0;
    cand    = '0;
    // Walk from the farthest candidate down so the nearest one is assigned last and wins.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDW'((int'(grant_id_q) + k) % N_REQ);
      if (req_valid[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // A frame (and its guard gap, if any) has fully ended this cycle.
  always_comb begin
    frame_done = 1'b0;
    if (state_q == S_WAIT_DONE && !tx_busy && GAP_CLKS == 0) frame_done = 1'b1;
    if (state_q == S_GAP && gap_cnt_q == '0)                 frame_done = 1'b1;
  end

  // Next-state and handshake logic.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    tx_byte_d  = tx_byte_q;
    gap_cnt_d  = gap_cnt_q;
    req_ready  = '0;
`ifdef UART_ARB_SRCID_EN
    payload_d  = payload_q;
    hdr_pend_d = hdr_pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A busy transmitter in IDLE is a frame we did not start; hold off granting.
        if (!rst && win_vld && !tx_busy) begin
          req_ready[win] = 1'b1;
          grant_id_d     = win;
          state_d        = S_ISSUE;
`ifdef UART_ARB_SRCID_EN
          tx_byte_d      = {4'hA, 4'(win)};
          payload_d      = req_data[8*win +: 8];
          hdr_pend_d     = 1'b1;
`else
          tx_byte_d      = req_data[8*win +: 8];
`endif
        end
      end
      S_ISSUE:    state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (tx_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!tx_busy && GAP_CLKS > 0) begin
          state_d   = S_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (gap_cnt_q != '0) gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // End of frame: either send the pending payload without rearbitrating, or go idle.
    if (frame_done) begin
`ifdef UART_ARB_SRCID_EN
      if (hdr_pend_q) begin
        state_d    = S_ISSUE;
        tx_byte_d  = payload_q;
        hdr_pend_d = 1'b0;
      end else begin
        state_d    = S_IDLE;
      end
`else
      state_d = S_IDLE;
`endif
    end
  end

  // State registers with synchronous reset; grant_id resets so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_id_q <= IDW'(N_REQ - 1);
      tx_byte_q  <= 8'h00;
      gap_cnt_q  <= '0;
`ifdef UART_ARB_SRCID_EN
      payload_q  <= 8'h00;
      hdr_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      tx_byte_q  <= tx_byte_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef UART_ARB_SRCID_EN
      payload_q  <= payload_d;
      hdr_pend_q <= hdr_pend_d;
`endif
    end
  end

  assign tx_start = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK);
  assign tx_byte  = tx_byte_q;
  assign grant_id = grant_id_q;
  // The gap between header and payload frames still counts as busy for the arbiter.
  assign active   = (state_q != S_IDLE) && ((state_q != S_GAP) || hdr_pend);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model.
// Transmitter goes busy 2 clks after seeing tx_start and stays busy BUSY_LEN clks.
// Checks reset, single grant, guard gap, round robin, reset mid-frame, stale busy.
module tb_uart_tx_arbiter;

  localparam int BUSY_LEN = 870;
  localparam int GAP      = 87;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int busy_cnt = 0;
  int st_cnt   = 0;
  bit auto_drop = 0;

  logic [7:0] sent[$];
  logic [3:0] grants[$];
  int         grant_cyc[$];
  int         rise_q[$];
  int         fall_q[$];

  uart_tx_arbiter #(.N_REQ(4), .GAP_CLKS(GAP), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample req_ready before the edge, then step the transmitter model after it.
  task automatic tick();
    logic [3:0] rr;
    #2;
    rr = req_ready;
    if (rr != 4'b0) begin
      grants.push_back(rr);
      grant_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (auto_drop) req_valid = req_valid & ~rr;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        tx_busy = 1'b0;
        fall_q.push_back(cyc);
      end
    end else if (tx_start) begin
      st_cnt++;
      if (st_cnt == 2) begin
        tx_busy  = 1'b1;
        busy_cnt = BUSY_LEN;
        st_cnt   = 0;
        sent.push_back(tx_byte);
        rise_q.push_back(cyc);
      end
    end else begin
      st_cnt = 0;
    end
  endtask

  // Run until transmitter and arbiter are quiet, then let any guard gap expire.
  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((active || tx_busy) && k < 3000) begin
      tick();
      k++;
    end
    check({tag, "_drain_timeout"}, {31'b0, active || tx_busy}, 32'd0);
    repeat (GAP + 3) tick();
  endtask

  initial begin
    int k;
    int base_s;
    int base_g;
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h13121110;
    tx_busy   = 1'b0;

    // Reset held 3 clocks with all requesters valid.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", {28'b0, req_ready}, 32'h0);
      check("rst_tx_start",  {31'b0, tx_start},  32'h0);
      check("rst_tx_byte",   {24'b0, tx_byte},   32'h00);
      check("rst_grant_id",  {30'b0, grant_id},  32'd3);
      check("rst_active",    {31'b0, active},    32'h0);
      tick();
    end
    check("rst_no_grants", grants.size(), 32'd0);
    rst = 1'b0;

`ifndef UART_ARB_SRCID_EN
    // Single request from requester 2.
    req_data  = 32'h135A1110;
    req_valid = 4'b0100;
    auto_drop = 1;
    tick();
    check("single_grants",   grants.size(), 32'd1);
    check("single_ready",    {28'b0, grants[0]}, 32'h4);
    check("single_grant_id", {30'b0, grant_id}, 32'd2);
    check("single_tx_start", {31'b0, tx_start}, 32'h1);
    check("single_tx_byte",  {24'b0, tx_byte},  32'h5A);
    check("single_active",   {31'b0, active},   32'h1);
    k = 0;
    while (sent.size() < 1 && k < 10) begin tick(); k++; end
    check("single_frame_started", sent.size(), 32'd1);
    check("single_start_held",    {31'b0, tx_start}, 32'h1);
    check("single_sent_byte",     {24'b0, sent[0]}, 32'h5A);
    tick();
    check("single_start_drop",    {31'b0, tx_start}, 32'h0);
    check("single_active_busy",   {31'b0, active},   32'h1);

    // Requester 2 re-raises during the frame: grant must wait exactly GAP+1 clks after busy falls.
    req_data  = 32'h135B1110;
    req_valid = 4'b0100;
    k = 0;
    while (grants.size() < 2 && k < 1200) begin tick(); k++; end
    check("gap_grants", grants.size(), 32'd2);
    check("gap_len",    grant_cyc[1] - fall_q[0], 32'd88);
    k = 0;
    while (sent.size() < 2 && k < 10) begin tick(); k++; end
    check("gap_sent_byte", {24'b0, sent[1]}, 32'h5B);

    // Reset in WAIT_DONE while the transmitter stays busy.
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midrst_tx_start", {31'b0, tx_start}, 32'h0);
    check("midrst_grant_id", {30'b0, grant_id}, 32'd3);
    check("midrst_active",   {31'b0, active},   32'h0);
    check("midrst_busy",     {31'b0, tx_busy},  32'h1);
    rst       = 1'b0;
    auto_drop = 0;
    req_data  = 32'h13121110;
    req_valid = 4'b1111;
    base_s = sent.size();
    base_g = grants.size();
    k = 0;
    while (tx_busy && k < 1000) begin tick(); k++; end
    check("stale_no_grant", grants.size() - base_g, 32'd0);

    // Round robin with all requesters continuously valid.
    k = 0;
    while (sent.size() < base_s + 5 && k < 6000) begin tick(); k++; end
    check("rr_frames", sent.size() - base_s, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_byte%0d", i),  {24'b0, sent[base_s + i]},   32'h10 + (i % 4));
      check($sformatf("rr_ready%0d", i), {28'b0, grants[base_g + i]}, 32'd1 << (i % 4));
    end
    req_valid = 4'b0000;
    drain("rr");

    // Foreign frame in IDLE: no grant until tx_busy drops, then grant immediately.
    tx_busy   = 1'b1;
    busy_cnt  = 20;
    auto_drop = 1;
    req_data  = 32'h131211A7;
    req_valid = 4'b0001;
    base_g = grants.size();
    repeat (19) tick();
    check("stale_hold", grants.size() - base_g, 32'd0);
    k = 0;
    while (grants.size() <= base_g && k < 10) begin tick(); k++; end
    check("stale_grant",       {28'b0, grants[base_g]}, 32'h1);
    check("stale_grant_delay", grant_cyc[base_g] - fall_q[fall_q.size() - 1], 32'd0);
    drain("stale");
    check("stale_sent_byte", {24'b0, sent[sent.size() - 1]}, 32'hA7);
`else
    begin
      bit act_drop;
      act_drop  = 0;
      req_data  = 32'h13C31110;
      req_valid = 4'b0100;
      auto_drop = 1;
      tick();
      check("srcid_grant_id", {30'b0, grant_id}, 32'd2);
      k = 0;
      while (sent.size() < 2 && k < 3000) begin
        tick();
        if (!active) act_drop = 1;
        k++;
      end
      check("srcid_frames",   sent.size(), 32'd2);
      check("srcid_header",   {24'b0, sent[0]}, 32'hA2);
      check("srcid_payload",  {24'b0, sent[1]}, 32'hC3);
      check("srcid_grants",   grants.size(), 32'd1);
      check("srcid_gap",      rise_q[1] - fall_q[0], 32'd89);
      check("srcid_active",   {31'b0, act_drop}, 32'h0);
      drain("srcid");
      check("srcid_grants_end", grants.size(), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
